// File: rtl/checker_arbiter.sv
// Round-robin record arbiter sharing one trace-format checker between two character sources.
// Optional length-limit abort is enabled by defining ARB_TIMEOUT_EN.
module checker_arbiter #(
  parameter int unsigned MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_char,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_char,
  output logic       req1_ready,
  output logic [7:0] chk_char,
  output logic       chk_reset,
  input  logic [1:0] chk_format,
  input  logic [3:0] chk_error,
  output logic       res_valid,
  output logic       res_owner,
  output logic [1:0] res_format,
  output logic [3:0] res_error,
  output logic       res_abort
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, CAPTURE} state_t;

  localparam logic [7:0] CH_START = 8'h5E;
  localparam logic [7:0] CH_END   = 8'h23;

  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_max_len_check
    $error("checker_arbiter: MAX_LEN must be in 1..255");
  end

  state_t     state, state_nx;
  logic       ptr, owner;
  logic       cand0, cand1;
  logic       grant, grant_src;
  logic       fwd;
  logic [7:0] fwd_char;
  logic       own_valid;
  logic [7:0] own_char;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LEN_LIMIT = MAX_LEN[7:0];
  logic [7:0] cnt, cnt_nx;
  logic       abort, abort_src;
`endif

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant      = 1'b0;
    grant_src  = ptr;
    fwd        = 1'b0;
    fwd_char   = '0;
    cand0      = req0_valid && (req0_char == CH_START);
    cand1      = req1_valid && (req1_char == CH_START);
    own_valid  = owner ? req1_valid : req0_valid;
    own_char   = owner ? req1_char  : req0_char;

    case (state)
      IDLE: begin
        // Non-start characters are swallowed so a source can resync onto its next '^'.
        req0_ready = req0_valid && !cand0;
        req1_ready = req1_valid && !cand1;
        if (cand0 && cand1) begin
          grant     = 1'b1;
          grant_src = ptr;
        end else if (cand0) begin
          grant     = 1'b1;
          grant_src = 1'b0;
        end else if (cand1) begin
          grant     = 1'b1;
          grant_src = 1'b1;
        end
        if (grant) begin
          if (grant_src) req1_ready = 1'b1;
          else           req0_ready = 1'b1;
          fwd      = 1'b1;
          fwd_char = CH_START;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        req0_ready = !owner && req0_valid;
        req1_ready =  owner && req1_valid;
        if (own_valid) begin
          fwd      = 1'b1;
          fwd_char = own_char;
          if (own_char == CH_END) state_nx = DRAIN;
        end
      end
      DRAIN:   state_nx = CAPTURE;
      CAPTURE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    cnt_nx    = cnt;
    abort     = 1'b0;
    abort_src = (state == IDLE) ? grant_src : owner;
    if (fwd) begin
      cnt_nx = (state == IDLE) ? 8'd1 : cnt + 8'd1;
      if (fwd_char != CH_END && cnt_nx == LEN_LIMIT) begin
        abort    = 1'b1;
        state_nx = IDLE;
      end
    end
`endif

    if (reset) begin
      state_nx   = IDLE;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      grant      = 1'b0;
      fwd        = 1'b0;
`ifdef ARB_TIMEOUT_EN
      abort      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      chk_char   <= '0;
      chk_reset  <= 1'b1;
      res_valid  <= 1'b0;
      res_owner  <= 1'b0;
      res_format <= '0;
      res_error  <= '0;
`ifdef ARB_TIMEOUT_EN
      res_abort  <= 1'b0;
      cnt        <= '0;
`endif
    end else begin
      state     <= state_nx;
      chk_char  <= fwd ? fwd_char : '0;
      chk_reset <= (state_nx == IDLE);
      res_valid <= 1'b0;
      if (grant) owner <= grant_src;
      if (state == CAPTURE) begin
        res_valid  <= 1'b1;
        res_owner  <= owner;
        res_format <= chk_format;
        res_error  <= chk_error;
        ptr        <= ~owner;
`ifdef ARB_TIMEOUT_EN
        res_abort  <= 1'b0;
`endif
      end
`ifdef ARB_TIMEOUT_EN
      if (fwd) cnt <= cnt_nx;
      if (abort) begin
        res_valid  <= 1'b1;
        res_owner  <= abort_src;
        res_format <= '0;
        res_error  <= '0;
        res_abort  <= 1'b1;
        ptr        <= ~abort_src;
      end
`endif
    end
  end

`ifndef ARB_TIMEOUT_EN
  assign res_abort = 1'b0;
`endif

endmodule

// File: tb/tb_checker_arbiter.sv
// Scoreboard bench for checker_arbiter: per-source expected-verdict queues, a stub checker,
// and a monitor that checks every res_valid pulse against the record text each source sent.
module tb_checker_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_MAX_LEN = 8;
`else
  localparam int TB_MAX_LEN = 64;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_char, req1_char;
  logic       req0_ready, req1_ready;
  logic [7:0] chk_char;
  logic       chk_reset;
  logic [1:0] chk_format = '0;
  logic [3:0] chk_error  = '0;
  logic       res_valid, res_owner, res_abort;
  logic [1:0] res_format;
  logic [3:0] res_error;

  checker_arbiter #(.MAX_LEN(TB_MAX_LEN)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_char(req0_char), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_char(req1_char), .req1_ready(req1_ready),
    .chk_char(chk_char), .chk_reset(chk_reset),
    .chk_format(chk_format), .chk_error(chk_error),
    .res_valid(res_valid), .res_owner(res_owner), .res_format(res_format),
    .res_error(res_error), .res_abort(res_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] fmt;
    logic [3:0] err;
    logic       abort;
  } verdict_t;

  verdict_t exp_q0[$];
  verdict_t exp_q1[$];
  int       own_log[$];
  int       last_hash[2];
  int       n_vec = 0;
  int       n_err = 0;

  // Stub checker: format 1 if the record contains '@' else 2, error = count of 'x';
  // any 8'h00 inside a record breaks it and yields format 0, error 0.
  logic       stub_in = 1'b0, stub_brk = 1'b0, stub_at = 1'b0;
  logic [3:0] stub_x = '0;
  always @(posedge clk) begin
    if (chk_reset === 1'b1) begin
      stub_in <= 1'b0; stub_brk <= 1'b0; stub_at <= 1'b0; stub_x <= '0;
      chk_format <= '0; chk_error <= '0;
    end else if (chk_char == 8'h5E) begin
      stub_in <= 1'b1; stub_brk <= 1'b0; stub_at <= 1'b0; stub_x <= '0;
    end else if (stub_in) begin
      if (chk_char == 8'h00) stub_brk <= 1'b1;
      else if (chk_char == 8'h23) begin
        stub_in    <= 1'b0;
        chk_format <= stub_brk ? 2'd0 : (stub_at ? 2'd1 : 2'd2);
        chk_error  <= stub_brk ? 4'd0 : stub_x;
      end else begin
        if (chk_char == 8'h40) stub_at <= 1'b1;
        if (chk_char == 8'h78) stub_x  <= stub_x + 4'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic verdict_t ref_verdict(input string body, input bit stalled);
    verdict_t v;
    int nx = 0;
    bit at = 0;
    v.fmt = 2'd0; v.err = 4'd0; v.abort = 1'b0;
`ifdef ARB_TIMEOUT_EN
    if (body.len() + 2 > TB_MAX_LEN) begin
      v.abort = 1'b1;
      return v;
    end
`endif
    if (stalled) return v;
    for (int i = 0; i < body.len(); i++) begin
      if (body[i] == "@") at = 1;
      if (body[i] == "x") nx++;
    end
    v.fmt = at ? 2'd1 : 2'd2;
    v.err = nx[3:0];
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset !== 1'b1 && res_valid === 1'b1) begin
      verdict_t e;
      own_log.push_back(int'(res_owner));
      if ((res_owner == 1'b0 && exp_q0.size() == 0) || (res_owner == 1'b1 && exp_q1.size() == 0)) begin
        n_vec++; n_err++;
        $display("FAIL unexpected verdict: owner %0d with nothing outstanding", res_owner);
      end else begin
        e = res_owner ? exp_q1.pop_front() : exp_q0.pop_front();
        check("res_format", res_format, e.fmt);
        check("res_error",  res_error,  e.err);
        check("res_abort",  res_abort,  e.abort);
        if (!e.abort) check("verdict latency", cyc - last_hash[res_owner], 3);
      end
    end
  end

  task automatic set_src(input int src, input logic v, input logic [7:0] c);
    if (src == 0) begin req0_valid = v; req0_char = c; end
    else          begin req1_valid = v; req1_char = c; end
  endtask

  task automatic drive_char(input int src, input logic [7:0] c);
    bit done = 0;
    set_src(src, 1'b1, c);
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if ((src == 0 && req0_ready === 1'b1) || (src == 1 && req1_ready === 1'b1)) begin
        done = 1;
        if (c == 8'h23) last_hash[src] = cyc;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL accept timeout: src%0d char %02h, got no ready, expected ready", src, c);
    end
  endtask

  task automatic idle(input int src, input int n);
    set_src(src, 1'b0, 8'h00);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_record(input int src, input string body, input int stall_at, input bit push);
    if (push) begin
      if (src == 0) exp_q0.push_back(ref_verdict(body, stall_at >= 0));
      else          exp_q1.push_back(ref_verdict(body, stall_at >= 0));
    end
    drive_char(src, 8'h5E);
    for (int i = 0; i < body.len(); i++) begin
      if (i == stall_at) idle(src, 1);
      drive_char(src, body[i]);
    end
    if (stall_at == body.len()) idle(src, 1);
    drive_char(src, 8'h23);
    set_src(src, 1'b0, 8'h00);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400; k++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic contention(input int first, input string b0, input string b1);
    int base = own_log.size();
    fork
      send_record(0, b0, -1, 1'b1);
      send_record(1, b1, -1, 1'b1);
      begin
        @(negedge clk);
        check("contention ready0", req0_ready, first == 0);
        check("contention ready1", req1_ready, first == 1);
      end
    join
    wait_drain();
    check("contention verdicts", own_log.size() - base, 2);
    if (own_log.size() >= base + 2) begin
      check("contention first owner",  own_log[base],     first);
      check("contention second owner", own_log[base + 1], 1 - first);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    string cs = "0123456789@x:$ <=a";
    int    base;
    last_hash[0] = 0; last_hash[1] = 0;
    reset = 1'b1;
    set_src(0, 1'b0, 8'h00);
    set_src(1, 1'b0, 8'h00);
    @(posedge clk); #1;

    // Reset state; ready must stay low while reset is high even with offers present.
    set_src(0, 1'b1, 8'h5E);
    set_src(1, 1'b1, "x");
    @(negedge clk);
    check("reset ready0",     req0_ready, 0);
    check("reset ready1",     req1_ready, 0);
    check("reset chk_char",   chk_char,   0);
    check("reset chk_reset",  chk_reset,  1);
    check("reset res_valid",  res_valid,  0);
    check("reset res_owner",  res_owner,  0);
    check("reset res_format", res_format, 0);
    check("reset res_error",  res_error,  0);
    check("reset res_abort",  res_abort,  0);
    set_src(0, 1'b0, 8'h00);
    set_src(1, 1'b0, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    contention(0, "ab@x", "xx12");
    contention(0, "7@7", "x9x");

    base = own_log.size();
    send_record(0, "10@00003000: $1 <= 0000000a", -1, 1'b1);
    wait_drain();
    check("single record verdicts", own_log.size() - base, 1);
    if (own_log.size() > base) check("single record owner", own_log[base], 0);

    contention(1, "@@", "x@");

    // Junk characters in IDLE are consumed and never reach the checker.
    set_src(1, 1'b1, "x");
    @(negedge clk);
    check("idle junk x ready", req1_ready, 1);
    @(posedge clk); #1;
    set_src(1, 1'b1, "y");
    @(negedge clk);
    check("idle junk y ready",  req1_ready, 1);
    check("idle junk chk_char", chk_char,   0);
    check("idle junk chk_reset", chk_reset, 1);
    @(posedge clk); #1;
    set_src(1, 1'b0, 8'h00);
    @(negedge clk);
    check("idle junk chk_char 2",  chk_char,  0);
    check("idle junk chk_reset 2", chk_reset, 1);
    @(posedge clk); #1;

    // Reset in the middle of a record drops it with no verdict and clears ptr.
    drive_char(0, 8'h5E);
    drive_char(0, "1");
    drive_char(0, "2");
    drive_char(0, "3");
    drive_char(0, "4");
    reset = 1'b1;
    set_src(0, 1'b0, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset chk_reset", chk_reset, 1);
    check("midreset chk_char",  chk_char,  0);
    check("midreset res_valid", res_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    contention(0, "a1", "b2");

`ifdef ARB_TIMEOUT_EN
    base = own_log.size();
    fork
      send_record(0, "0123456789", -1, 1'b1);
      begin
        repeat (2) @(posedge clk);
        #1;
        send_record(1, "x@", -1, 1'b1);
      end
    join
    wait_drain();
    check("timeout verdicts", own_log.size() - base, 2);
    if (own_log.size() >= base + 2) begin
      check("timeout first owner",  own_log[base],     0);
      check("timeout second owner", own_log[base + 1], 1);
    end
`endif

    fork
      for (int r = 0; r < 12; r++) begin
        string b = "";
        int    n = $urandom_range(1, 12);
        int    g = $urandom_range(0, 3);
        if (g > 0) idle(0, g);
        if ($urandom_range(0, 4) == 0) begin drive_char(0, "z"); set_src(0, 1'b0, 8'h00); end
        for (int i = 0; i < n; i++) begin
          int k = $urandom_range(0, cs.len() - 1);
          b = {b, cs.substr(k, k)};
        end
        send_record(0, b, ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1, 1'b1);
      end
      for (int r = 0; r < 12; r++) begin
        string b = "";
        int    n = $urandom_range(1, 12);
        int    g = $urandom_range(0, 3);
        if (g > 0) idle(1, g);
        if ($urandom_range(0, 4) == 0) begin drive_char(1, "z"); set_src(1, 1'b0, 8'h00); end
        for (int i = 0; i < n; i++) begin
          int k = $urandom_range(0, cs.len() - 1);
          b = {b, cs.substr(k, k)};
        end
        send_record(1, b, ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1, 1'b1);
      end
    join
    wait_drain();

    check("outstanding src0 verdicts", exp_q0.size(), 0);
    check("outstanding src1 verdicts", exp_q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
